// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute-stage ALU with a 2-entry skid-buffered valid/ready output stage
module ex_alu_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alu_control,
    input  logic [XLEN-1:0]  in_op_a,
    input  logic [XLEN-1:0]  in_op_b,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_illegal,
    output logic [CNT_W-1:0] op_count
);
    localparam int EW = XLEN + 8;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state;
    logic [XLEN-1:0] res;
    logic            ill;
    logic            rw;
    logic [EW-1:0]   ent;
    logic [EW-1:0]   main_q;
    logic [EW-1:0]   skid_q;
    logic            it;
    logic            ot;

    // decode the control code; NOP and undefined codes never write the register file
    always_comb begin
        res = '0;
        ill = 1'b0;
        rw  = in_reg_write;
        case (in_alu_control)
            4'b0000: res = in_op_a & in_op_b;
            4'b0001: res = in_op_a | in_op_b;
            4'b0010: res = in_op_a + in_op_b;
            4'b0110: res = in_op_a - in_op_b;
            4'b0111: res = {{(XLEN-1){1'b0}}, $signed(in_op_a) < $signed(in_op_b)};
            4'b1111: rw = 1'b0;
            default: begin
                rw  = 1'b0;
                ill = 1'b1;
            end
        endcase
    end

    assign ent = {ill, rw, in_rd, res == '0, res};
    assign {out_illegal, out_reg_write, out_rd, out_zero, out_result} = main_q;
    assign out_valid = (state != EMPTY);
    assign it = in_valid & in_ready & ~flush;
    assign ot = out_valid & out_ready;

    // buffer FSM: main entry drives the outputs, skid absorbs one op while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            in_ready <= 1'b1;
            op_count <= '0;
        end else begin
            if (it) op_count <= op_count + CNT_W'(1);
            if (flush) begin
                state    <= EMPTY;
                main_q   <= '0;
                skid_q   <= '0;
                in_ready <= 1'b1;
            end else begin
                case (state)
                    EMPTY: if (it) begin
                        main_q <= ent;
                        state  <= ONE;
                    end
                    ONE: if (it && !ot) begin
                        skid_q   <= ent;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (it) begin
                        main_q <= ent;
                    end else if (ot) begin
                        state <= EMPTY;
                    end
                    TWO: if (ot) begin
                        main_q   <= skid_q;
                        skid_q   <= '0;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed vector table plus stall, flush and async-reset sequences
module tb_ex_alu_stage;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [3:0]  in_alu_control = 0;
    logic [31:0] in_op_a = 0;
    logic [31:0] in_op_b = 0;
    logic [4:0]  in_rd = 0;
    logic        in_reg_write = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_illegal;
    logic [31:0] op_count;

    int checks = 0;
    int failures = 0;

    ex_alu_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_control(in_alu_control), .in_op_a(in_op_a), .in_op_b(in_op_b),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_illegal(out_illegal),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic        rw;
        logic [31:0] r;
        logic        z;
        logic        orw;
        logic        ill;
    } vec_t;

    vec_t v[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw);
        in_valid = 1;
        in_alu_control = c;
        in_op_a = a;
        in_op_b = b;
        in_rd = rd;
        in_reg_write = rw;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 0, 1, 0};
        v[1]  = '{4'b0110, 32'd5,        32'd5,        1, 32'h00000000, 1, 1, 0};
        v[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000001, 0, 1, 0};
        v[3]  = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 1, 32'h00000000, 1, 1, 0};
        v[4]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 0, 1, 0};
        v[5]  = '{4'b0001, 32'h0F0F0000, 32'h000000F0, 0, 32'h0F0F00F0, 0, 0, 0};
        v[6]  = '{4'b0011, 32'h12345678, 32'h1,        1, 32'h00000000, 1, 0, 1};
        v[7]  = '{4'b1111, 32'h12345678, 32'h1,        1, 32'h00000000, 1, 0, 0};
        v[8]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, 0, 0};
        v[9]  = '{4'b0110, 32'h00000000, 32'h00000001, 1, 32'hFFFFFFFF, 0, 1, 0};
        v[10] = '{4'b1000, 32'h5,        32'h6,        1, 32'h00000000, 1, 0, 1};

        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_op_count", op_count, 0);
        chk("rst_out_result", out_result, 0);
        @(negedge clk);
        rst_n = 1;

        @(posedge clk);
        #1;
        out_ready = 1;
        for (int i = 0; i < 11; i++) begin
            drive(v[i].ctl, v[i].a, v[i].b, 5'(i + 1), v[i].rw);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("v%0d_result", i), out_result, v[i].r);
            chk($sformatf("v%0d_zero", i), 32'(out_zero), 32'(v[i].z));
            chk($sformatf("v%0d_rw", i), 32'(out_reg_write), 32'(v[i].orw));
            chk($sformatf("v%0d_ill", i), 32'(out_illegal), 32'(v[i].ill));
            chk($sformatf("v%0d_rd", i), 32'(out_rd), i + 1);
            if (i == 0) chk("v0_count", op_count, 1);
        end
        in_valid = 0;
        tick();
        chk("drain_valid", 32'(out_valid), 0);
        chk("table_count", op_count, 11);

        out_ready = 0;
        drive(4'b0010, 1, 1, 5'd1, 1);
        tick();
        chk("stall_A_valid", 32'(out_valid), 1);
        chk("stall_ready_after_A", 32'(in_ready), 1);
        drive(4'b0010, 3, 3, 5'd2, 1);
        tick();
        chk("stall_ready_after_B", 32'(in_ready), 0);
        chk("stall_hold_A", out_result, 2);
        drive(4'b0010, 10, 10, 5'd3, 1);
        tick();
        chk("stall_C_blocked", 32'(in_ready), 0);
        chk("stall_still_A", out_result, 2);
        chk("stall_count", op_count, 13);
        out_ready = 1;
        tick();
        chk("emerge_B", out_result, 6);
        chk("emerge_B_rd", 32'(out_rd), 2);
        chk("ready_reopened", 32'(in_ready), 1);
        tick();
        chk("emerge_C", out_result, 20);
        chk("emerge_C_rd", 32'(out_rd), 3);
        in_valid = 0;
        tick();
        chk("stall_drained", 32'(out_valid), 0);
        chk("stall_total_count", op_count, 14);

        out_ready = 0;
        drive(4'b0010, 7, 0, 5'd4, 1);
        tick();
        drive(4'b0010, 8, 0, 5'd5, 1);
        tick();
        chk("pre_flush_full", 32'(in_ready), 0);
        flush = 1;
        drive(4'b0010, 9, 0, 5'd6, 1);
        tick();
        flush = 0;
        in_valid = 0;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_ready", 32'(in_ready), 1);
        chk("flush_count", op_count, 16);
        drive(4'b0001, 1, 2, 5'd7, 1);
        tick();
        flush = 1;
        drive(4'b0001, 4, 8, 5'd8, 1);
        tick();
        flush = 0;
        in_valid = 0;
        chk("flush1_valid", 32'(out_valid), 0);
        chk("flush1_count", op_count, 17);
        tick();
        chk("flush1_idle", 32'(out_valid), 0);

        drive(4'b0010, 1, 1, 5'd1, 1);
        tick();
        drive(4'b0010, 2, 2, 5'd2, 1);
        tick();
        in_valid = 0;
        #3;
        rst_n = 0;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_count", op_count, 0);
        chk("async_ready", 32'(in_ready), 1);
        chk("async_result", out_result, 0);
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        drive(4'b0010, 2, 3, 5'd9, 1);
        tick();
        in_valid = 0;
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_result", out_result, 5);
        chk("post_rst_count", op_count, 1);
        tick();
        chk("post_rst_drain", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
